// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: the tracked
// in-flight stage entry, forwarding mode encodings and the ID operand-use helper.
package hazard_forward_unit_pkg;

  localparam int unsigned ENTRY_AW = 5;

  localparam logic FWD_MODE   = 1'b1;
  localparam logic STALL_MODE = 1'b0;

  localparam logic [1:0] BR_TYPE_BNE = 2'b10;

  typedef struct packed {
    logic                v;
    logic [ENTRY_AW-1:0] dest;
    logic                wb;
    logic                ld;
    logic [ENTRY_AW-1:0] src1;
    logic [ENTRY_AW-1:0] src2;
    logic                use2;
  } stage_entry_t;

  // BNE compares both registers, so it reads src2 like R-type and stores do.
  function automatic logic uses_src2(input logic is_rtype, input logic is_store,
                                     input logic [1:0] br_type);
    return is_rtype | is_store | (br_type == BR_TYPE_BNE);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_match.sv
// Per-stage comparator: decides whether one tracked stage blocks the ID
// instruction and whether it can feed either EXE operand.
module hazard_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned STAGE    = 0,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic                v,
  input  logic                wb,
  input  logic                ld,
  input  logic [ENTRY_AW-1:0] dest,
  input  logic [ENTRY_AW-1:0] id_src1,
  input  logic [ENTRY_AW-1:0] id_src2,
  input  logic                id_use2,
  input  logic [ENTRY_AW-1:0] exe_src1,
  input  logic [ENTRY_AW-1:0] exe_src2,
  input  logic                exe_use2,
  output logic                stall_only_hit,
  output logic                load_use_hit,
  output logic                fwd1_ok,
  output logic                fwd2_ok
);

  localparam logic IN_STALL_WIN = (STAGE + 2 <= DEPTH);
  // A load at stage k sits at k+1 once the consumer reaches EXE, so the
  // interlock only has to cover stages whose successor is not yet forwardable.
  localparam logic IN_LOAD_WIN  = (STAGE + 1 < LOAD_LAT);
  localparam logic CAN_FWD      = (STAGE >= 1);
  localparam logic LOAD_READY   = (STAGE >= LOAD_LAT);

  logic writer;
  logic id_match;
  logic fwd_src_ok;

  always_comb begin
    writer         = v & wb & (dest != '0);
    id_match       = writer & ((dest == id_src1) | (id_use2 & (dest == id_src2)));
    stall_only_hit = IN_STALL_WIN & id_match;
    load_use_hit   = IN_LOAD_WIN & id_match & ld;
    fwd_src_ok     = CAN_FWD & writer & (~ld | LOAD_READY);
    fwd1_ok        = fwd_src_ok & (dest == exe_src1);
    fwd2_ok        = fwd_src_ok & exe_use2 & (dest == exe_src2);
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and EXE operand forwarding over a shift register of
// in-flight instructions, with load-use interlock and a saturating stall counter.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [AW-1:0]       id_src1,
  input  logic [AW-1:0]       id_src2,
  input  logic                id_use2,
  input  logic [AW-1:0]       id_dest,
  input  logic                id_wb_en,
  input  logic                id_mem_r_en,
  input  logic                fwd_en,
  input  logic                freeze,
  input  logic                flush,
  input  logic [DEPTH*DW-1:0] stage_result,
  output logic                stall,
  output logic                fwd1_hit,
  output logic                fwd2_hit,
  output logic [DW-1:0]       fwd1_val,
  output logic [DW-1:0]       fwd2_val,
  output logic [CNT_W-1:0]    stall_cycles
);

  if (AW != ENTRY_AW) begin : g_bad_aw
    $error("hazard_forward_unit: AW must equal ENTRY_AW");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("hazard_forward_unit: DEPTH must be at least 2");
  end
  if (LOAD_LAT < 1 || LOAD_LAT >= DEPTH) begin : g_bad_lat
    $error("hazard_forward_unit: LOAD_LAT must be in 1..DEPTH-1");
  end

  stage_entry_t     entries [DEPTH];
  stage_entry_t     id_entry;
  logic             issue;
  logic [DEPTH-1:0] stall_only_vec;
  logic [DEPTH-1:0] load_use_vec;
  logic [DEPTH-1:0] fwd1_vec;
  logic [DEPTH-1:0] fwd2_vec;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    hazard_match #(
      .STAGE    (k),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
    ) u_match (
      .v              (entries[k].v),
      .wb             (entries[k].wb),
      .ld             (entries[k].ld),
      .dest           (entries[k].dest),
      .id_src1        (id_src1),
      .id_src2        (id_src2),
      .id_use2        (id_use2),
      .exe_src1       (entries[0].src1),
      .exe_src2       (entries[0].src2),
      .exe_use2       (entries[0].use2),
      .stall_only_hit (stall_only_vec[k]),
      .load_use_hit   (load_use_vec[k]),
      .fwd1_ok        (fwd1_vec[k]),
      .fwd2_ok        (fwd2_vec[k])
    );
  end

  always_comb begin
    stall = 1'b0;
    case (fwd_en)
      FWD_MODE:   stall = id_valid & (|load_use_vec);
      STALL_MODE: stall = id_valid & (|stall_only_vec);
    endcase
  end

  always_comb begin
    issue    = id_valid & ~stall & ~flush;
    id_entry = '{v: 1'b1, dest: id_dest, wb: id_wb_en, ld: id_mem_r_en,
                 src1: id_src1, src2: id_src2, use2: id_use2};
  end

  // Scan oldest to youngest so the youngest producer overwrites older ones.
  always_comb begin
    fwd1_hit = 1'b0;
    fwd2_hit = 1'b0;
    fwd1_val = '0;
    fwd2_val = '0;
    if (fwd_en && entries[0].v) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (fwd1_vec[k]) begin
          fwd1_hit = 1'b1;
          fwd1_val = stage_result[k*DW +: DW];
        end
        if (fwd2_vec[k]) begin
          fwd2_hit = 1'b1;
          fwd2_val = stage_result[k*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries[k] <= '0;
      end
    end else if (!freeze) begin
      entries[0] <= issue ? id_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && !freeze && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: stalls, forwarding, load-use,
// r0 handling, freeze/flush, async reset and counter saturation.
module tb_hazard_forward_unit;
  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_LAT = 2;
  // Narrow counter so saturation is reached in a few thousand cycles.
  localparam int unsigned CNT_W    = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid, id_use2, id_wb_en, id_mem_r_en;
  logic [AW-1:0]       id_src1, id_src2, id_dest;
  logic                fwd_en, freeze, flush;
  logic [DEPTH*DW-1:0] stage_result;
  logic                stall, fwd1_hit, fwd2_hit;
  logic [DW-1:0]       fwd1_val, fwd2_val;
  logic [CNT_W-1:0]    stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_forward_unit #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_use2(id_use2), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .fwd_en(fwd_en),
    .freeze(freeze), .flush(flush), .stage_result(stage_result),
    .stall(stall), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_val(fwd1_val), .fwd2_val(fwd2_val), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input logic u2, input logic [AW-1:0] d, input logic wb,
                        input logic ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_use2 = u2;
    id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) next();
  endtask

  initial begin
    rst = 1'b0;
    fwd_en = 1'b0; freeze = 1'b0; flush = 1'b0;
    stage_result = {32'hDEADBEEF, 32'h00000005, 32'h11111111};
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_hit1", fwd1_hit, 0);
    chk("rst_val2", fwd2_val, 0);
    chk("rst_cnt", stall_cycles, 0);
    rst = 1'b1;
    next();

    // 1: stall-only mode, dependent consumer waits two cycles
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    chk("t1_producer_nostall", stall, 0);
    next();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0); #1;
    chk("t1_stall_a", stall, 1);
    next(); #1;
    chk("t1_stall_b", stall, 1);
    next(); #1;
    chk("t1_release", stall, 0);
    chk("t1_cnt", stall_cycles, 2);
    next();
    drain();

    // 2: forwarding mode, ALU result forwarded from MEM
    fwd_en = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); #1;
    chk("t2_producer_nostall", stall, 0);
    next();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    chk("t2_consumer_nostall", stall, 0);
    next();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t2_hit1", fwd1_hit, 1);
    chk("t2_val1", fwd1_val, 32'h00000005);
    chk("t2_hit2", fwd2_hit, 0);
    chk("t2_val2", fwd2_val, 0);
    next();
    drain();

    // 3a: load-use, one stall then forward from stage 2
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1); #1;
    chk("t3_lw_nostall", stall, 0);
    next();
    set_id(1'b1, 5'd4, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    chk("t3_loaduse", stall, 1);
    next(); #1;
    chk("t3_release", stall, 0);
    next();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t3_hit1", fwd1_hit, 1);
    chk("t3_val1", fwd1_val, 32'hDEADBEEF);
    chk("t3_hit2", fwd2_hit, 1);
    chk("t3_val2", fwd2_val, 32'hDEADBEEF);
    chk("t3_cnt", stall_cycles, 3);
    next();
    drain();

    // 3b: youngest producer (non-load at k=1) beats the load at k=2
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    next();
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); #1;
    chk("t3b_addi_nostall", stall, 0);
    next();
    set_id(1'b1, 5'd4, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    chk("t3b_nostall", stall, 0);
    next();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk("t3b_val1", fwd1_val, 32'h00000005);
    chk("t3b_val2", fwd2_val, 32'h00000005);
    next();
    drain();

    // 4: r0 never hazards or forwards, both modes
    for (int m = 0; m < 2; m++) begin
      fwd_en = (m == 1);
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
      next();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0); #1;
      chk("t4_r0_nostall", stall, 0);
      next();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
      chk("t4_r0_hit1", fwd1_hit, 0);
      chk("t4_r0_hit2", fwd2_hit, 0);
      chk("t4_r0_val1", fwd1_val, 0);
      chk("t4_r0_val2", fwd2_val, 0);
      next();
      drain();
    end

    // 5: flush kills an issuing instruction; freeze holds; flush with stall
    fwd_en = 1'b0;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    flush = 1'b1;
    next();
    flush = 1'b0;
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); #1;
    chk("t5_flush_kill", stall, 0);
    next();
    drain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    next();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    freeze = 1'b1; #1;
    chk("t5_stall_in_freeze", stall, 1);
    for (int i = 0; i < 3; i++) begin
      next();
      chk("t5_freeze_stall", stall, 1);
      chk("t5_freeze_cnt", stall_cycles, 3);
    end
    freeze = 1'b0;
    flush = 1'b1; #1;
    chk("t5_flush_stall", stall, 1);
    next();
    flush = 1'b0; #1;
    chk("t5_flush_nocount", stall_cycles, 3);
    chk("t5_after_flush", stall, 1);
    next(); #1;
    chk("t5_release", stall, 0);
    chk("t5_cnt", stall_cycles, 4);
    next();
    drain();

    // 6: async reset mid-stall, then saturation
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    next();
    set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); #1;
    chk("t6_pre_stall", stall, 1);
    next();
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_cnt", stall_cycles, 0);
    chk("t6_rst_hit1", fwd1_hit, 0);
    #1 rst = 1'b1;
    #1;
    chk("t6_post_rst_nostall", stall, 0);
    drain();
    chk("t6_cnt_zero", stall_cycles, 0);
    set_id(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    repeat (1530) next();
    chk("t6_cnt_1020", stall_cycles, 10'd1020);
    repeat (3) next();
    chk("t6_cnt_1022", stall_cycles, 10'd1022);
    repeat (3) next();
    chk("t6_cnt_sat", stall_cycles, 10'h3FF);
    repeat (30) next();
    chk("t6_cnt_hold", stall_cycles, 10'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
